// File: rtl/int_sequencer.sv
// int_sequencer: sequences interrupt entry (save EPC, jump to vector) and return for a
// simple PC-based core; NMI is edge-captured, INT is a masked level.
module int_sequencer #(
    parameter logic [31:0] INT_VEC = 32'h0000_0080,
    parameter logic [31:0] NMI_VEC = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        INT,
    input  logic        INTD,
    input  logic        NMI,
    input  logic        instr_done,
    input  logic        eret,
    input  logic [31:0] PC_out,
    output logic        stall_req,
    output logic        vec_load,
    output logic [31:0] vec_pc,
    output logic [31:0] epc,
    output logic [1:0]  cause,
    output logic        in_service
);
    typedef enum logic [2:0] {IDLE, PEND, SAVE, JUMP, SVC, RET} state_t;

    state_t      state_q, state_d;
    logic        nmi_q, nmi_pend_q, nmi_pend_d, ie_q, ie_d, rdy_q;
    logic        int_pend, any_pend;
    logic [31:0] epc_q, epc_d;
    logic [1:0]  cause_q, cause_d;

    // rdy_q holds the FSM in IDLE for the first edge after reset release
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            nmi_q      <= 1'b1;
            nmi_pend_q <= 1'b0;
            ie_q       <= 1'b1;
            rdy_q      <= 1'b0;
            epc_q      <= '0;
            cause_q    <= '0;
        end else begin
            state_q    <= state_d;
            nmi_q      <= NMI;
            nmi_pend_q <= nmi_pend_d;
            ie_q       <= ie_d;
            rdy_q      <= 1'b1;
            epc_q      <= epc_d;
            cause_q    <= cause_d;
        end
    end

    always_comb begin
        int_pend   = INT & ~INTD & ie_q;
        any_pend   = nmi_pend_q | int_pend;
        state_d    = state_q;
        nmi_pend_d = nmi_pend_q | (NMI & ~nmi_q);
        ie_d       = ie_q;
        epc_d      = epc_q;
        cause_d    = cause_q;
        case (state_q)
            IDLE: if (any_pend && rdy_q) state_d = PEND;
            PEND: if (instr_done) state_d = any_pend ? SAVE : IDLE;
            SAVE: begin
                state_d = JUMP;
                epc_d   = PC_out;
                cause_d = nmi_pend_q ? 2'b10 : 2'b01;
                ie_d    = 1'b0;
                if (nmi_pend_q) nmi_pend_d = 1'b0;
            end
            JUMP: state_d = SVC;
            SVC:  if (eret) state_d = RET;
            RET: begin
                state_d = IDLE;
                ie_d    = 1'b1;
                cause_d = 2'b00;
            end
            default: state_d = IDLE;
        endcase
    end

    assign stall_req  = (state_q == PEND) || (state_q == SAVE) || (state_q == JUMP);
    assign vec_load   = (state_q == JUMP) || (state_q == RET);
    assign vec_pc     = (state_q == JUMP) ? ((cause_q == 2'b10) ? NMI_VEC : INT_VEC) :
                        (state_q == RET)  ? epc_q : 32'h0;
    assign epc        = epc_q;
    assign cause      = cause_q;
    assign in_service = (state_q == SVC);
endmodule
